// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA raster timing generator with registered sync, blank and
// colour outputs. The pixel and line counters are free-running. Sync, blank
// and colour are decoded from the counter registers and then registered, so
// they lag x_cnt/y_cnt by one clock.
// Optional feature: define VGA_TEST_PATTERN_EN to add a pattern_en input that
// replaces the incoming colour with eight vertical colour bars.
module vga_sync_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       clk,
  input  logic       rst,
`ifdef VGA_TEST_PATTERN_EN
  input  logic       pattern_en,
`endif
  input  logic [7:0] r_data,
  input  logic [7:0] g_data,
  input  logic [7:0] b_data,
  output logic [9:0] x_cnt,
  output logic [9:0] y_cnt,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic       vga_blank_n,
  output logic       vga_sync_n,
  output logic [7:0] vga_r,
  output logic [7:0] vga_g,
  output logic [7:0] vga_b,
  output logic       frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT_END  = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT_END  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_FIRST   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_LAST    = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_LAST    = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic       active;
  logic       hs_raw;
  logic       vs_raw;
  logic [7:0] pix_r;
  logic [7:0] pix_g;
  logic [7:0] pix_b;

  // Free-running raster counters; y advances on the same edge that x wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_cnt <= '0;
      y_cnt <= '0;
    end else if (x_cnt == H_LAST) begin
      x_cnt <= '0;
      if (y_cnt == V_LAST) y_cnt <= '0;
      else                 y_cnt <= y_cnt + 10'd1;
    end else begin
      x_cnt <= x_cnt + 10'd1;
    end
  end

  // Timing decode straight from the counter registers (before the output stage).
  always_comb begin
    active = (x_cnt < H_ACT_END) && (y_cnt < V_ACT_END);
    hs_raw = !((x_cnt >= HS_FIRST) && (x_cnt <= HS_LAST));
    vs_raw = !((y_cnt >= VS_FIRST) && (y_cnt <= VS_LAST));
  end

`ifdef VGA_TEST_PATTERN_EN
  localparam logic [9:0] BAR_W = 10'(H_ACTIVE / 8);

  logic [9:0] bar_full;
  logic [2:0] bar;

  // Colour source select: bar pattern (white..black, left to right) or input colour.
  always_comb begin
    bar_full = x_cnt / BAR_W;
    bar      = (bar_full > 10'd7) ? 3'd7 : bar_full[2:0];
    pix_r    = r_data;
    pix_g    = g_data;
    pix_b    = b_data;
    if (pattern_en) begin
      case (bar)
        3'd0:    {pix_r, pix_g, pix_b} = 24'hFFFFFF;
        3'd1:    {pix_r, pix_g, pix_b} = 24'hFFFF00;
        3'd2:    {pix_r, pix_g, pix_b} = 24'h00FFFF;
        3'd3:    {pix_r, pix_g, pix_b} = 24'h00FF00;
        3'd4:    {pix_r, pix_g, pix_b} = 24'hFF00FF;
        3'd5:    {pix_r, pix_g, pix_b} = 24'hFF0000;
        3'd6:    {pix_r, pix_g, pix_b} = 24'h0000FF;
        default: {pix_r, pix_g, pix_b} = 24'h000000;
      endcase
    end
  end
`else
  // Colour source: always the renderer-supplied colour.
  always_comb begin
    pix_r = r_data;
    pix_g = g_data;
    pix_b = b_data;
  end
`endif

  // Output stage: one clock behind the counters, colour forced to zero in blanking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
      vga_blank_n <= 1'b0;
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
    end else begin
      vga_hs      <= hs_raw;
      vga_vs      <= vs_raw;
      vga_blank_n <= active;
      vga_r       <= active ? pix_r : 8'd0;
      vga_g       <= active ? pix_g : 8'd0;
      vga_b       <= active ? pix_b : 8'd0;
    end
  end

  // Frame marker is combinational on the counter origin and masked by reset.
  always_comb begin
    frame_start = !rst && (x_cnt == 10'd0) && (y_cnt == 10'd0);
  end

  assign vga_sync_n = 1'b0;

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: bench for vga_sync_gen using a reduced raster so whole
// frames fit in a short run. A reference model pushes the expected
// post-edge outputs on every rising edge, and a scoreboard pops and compares
// them on the falling edge. Scenario tasks add targeted timing checks.
// Define VGA_TEST_PATTERN_EN to build and check the colour-bar option.
`timescale 1ns/1ps
module tb_vga_sync_gen;

  localparam int HA = 64, HF = 8, HSW = 12, HB = 12;
  localparam int VA = 8,  VF = 2, VSW = 2,  VB = 3;
  localparam int HT = HA + HF + HSW + HB;   // 96
  localparam int VT = VA + VF + VSW + VB;   // 15
  localparam int HS0 = HA + HF;             // first hsync pixel
  localparam int VS0 = VA + VF;             // first vsync line
  localparam int BW = HA / 8;
  localparam int FRAME = HT * VT;

  // clock/reset block
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       pattern_en;
  logic [7:0] r_data, g_data, b_data;
  logic [9:0] x_cnt, y_cnt;
  logic       vga_hs, vga_vs, vga_blank_n, vga_sync_n, frame_start;
  logic [7:0] vga_r, vga_g, vga_b;

  int vectors = 0;
  int miscompares = 0;

  vga_sync_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB)
  ) dut (
    .clk(clk),
    .rst(rst),
`ifdef VGA_TEST_PATTERN_EN
    .pattern_en(pattern_en),
`endif
    .r_data(r_data),
    .g_data(g_data),
    .b_data(b_data),
    .x_cnt(x_cnt),
    .y_cnt(y_cnt),
    .vga_hs(vga_hs),
    .vga_vs(vga_vs),
    .vga_blank_n(vga_blank_n),
    .vga_sync_n(vga_sync_n),
    .vga_r(vga_r),
    .vga_g(vga_g),
    .vga_b(vga_b),
    .frame_start(frame_start)
  );

  // expected word: x(10) y(10) hs vs blank_n rgb(24) frame_start = 48 bits
  logic [47:0] exp_q[$];
  logic [23:0] bar_rgb [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                               24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
  int mx, my;
  logic pat_sel;

`ifdef VGA_TEST_PATTERN_EN
  assign pat_sel = pattern_en;
`else
  assign pat_sel = 1'b0;
`endif

  // reference model: expected outputs after each rising edge
  always @(posedge clk or posedge rst) begin
    logic m_act, m_hs, m_vs, m_fs;
    logic [23:0] m_rgb;
    if (rst) begin
      mx = 0;
      my = 0;
    end else begin
      m_act = (mx < HA) && (my < VA);
      m_hs  = !((mx >= HS0) && (mx < HS0 + HSW));
      m_vs  = !((my >= VS0) && (my < VS0 + VSW));
      if (!m_act)       m_rgb = 24'h0;
      else if (pat_sel) m_rgb = bar_rgb[mx / BW];
      else              m_rgb = {r_data, g_data, b_data};
      if (mx == HT - 1) begin
        mx = 0;
        my = (my == VT - 1) ? 0 : my + 1;
      end else begin
        mx = mx + 1;
      end
      m_fs = (mx == 0) && (my == 0);
      exp_q.push_back({10'(mx), 10'(my), m_hs, m_vs, m_act, m_rgb, m_fs});
    end
  end

  // scoreboard: pop and compare on the falling edge
  always @(negedge clk) begin
    logic [47:0] got, exp;
    if (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      got = {x_cnt, y_cnt, vga_hs, vga_vs, vga_blank_n, vga_r, vga_g, vga_b, frame_start};
      vectors++;
      if (got !== exp) begin
        miscompares++;
        if (miscompares <= 30)
          $display("FAIL scoreboard t=%0t got x=%0d y=%0d hs=%b vs=%b bn=%b rgb=%h fs=%b expected x=%0d y=%0d hs=%b vs=%b bn=%b rgb=%h fs=%b",
                   $time, got[47:38], got[37:28], got[27], got[26], got[25], got[24:1], got[0],
                   exp[47:38], exp[37:28], exp[27], exp[26], exp[25], exp[24:1], exp[0]);
      end
    end
  end

  task automatic test_reset();
    repeat (3) @(negedge clk);
    vectors++;
    if ({x_cnt, y_cnt} !== 20'd0) begin
      miscompares++;
      $display("FAIL reset_counters got x=%0d y=%0d expected 0 0", x_cnt, y_cnt);
    end
    vectors++;
    if ({vga_hs, vga_vs, vga_blank_n} !== 3'b110) begin
      miscompares++;
      $display("FAIL reset_sync got hs/vs/bn=%b expected 110", {vga_hs, vga_vs, vga_blank_n});
    end
    vectors++;
    if ({vga_r, vga_g, vga_b} !== 24'h0) begin
      miscompares++;
      $display("FAIL reset_rgb got %h expected 000000", {vga_r, vga_g, vga_b});
    end
    vectors++;
    if ({frame_start, vga_sync_n} !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_fs_syncn got fs=%b sync_n=%b expected 0 0", frame_start, vga_sync_n);
    end
    rst = 1'b0;
  endtask

  task automatic test_frame_wrap();
    int fs_cnt = 0, xwrap = 0, ywrap = 0, over = 0;
    logic [9:0] px, py;
    @(negedge clk);
    vectors++;
    if ({x_cnt, y_cnt} !== {10'd1, 10'd0}) begin
      miscompares++;
      $display("FAIL release_start got x=%0d y=%0d expected 1 0", x_cnt, y_cnt);
    end
    px = x_cnt; py = y_cnt;
    if (frame_start) fs_cnt++;
    for (int i = 1; i < FRAME; i++) begin
      @(negedge clk);
      if (frame_start) fs_cnt++;
      if (px == 10'(HT - 1) && x_cnt == 10'd0) xwrap++;
      if (py == 10'(VT - 1) && y_cnt == 10'd0) ywrap++;
      if (x_cnt > 10'(HT - 1) || y_cnt > 10'(VT - 1)) over++;
      px = x_cnt; py = y_cnt;
    end
    vectors++;
    if (fs_cnt != 1 || !frame_start || x_cnt !== 10'd0 || y_cnt !== 10'd0) begin
      miscompares++;
      $display("FAIL frame_start_once got count=%0d last fs=%b expected 1 pulse at (0,0)", fs_cnt, frame_start);
    end
    vectors++;
    if (xwrap != VT || ywrap != 1 || over != 0) begin
      miscompares++;
      $display("FAIL counter_wrap got xwraps=%0d ywraps=%0d overs=%0d expected %0d 1 0", xwrap, ywrap, over, VT);
    end
  endtask

  task automatic test_hsync();
    int n = 0, low = 0;
    do begin @(negedge clk); n++; end while (x_cnt !== 10'(HS0) && n < HT + 2);
    vectors++;
    if (x_cnt !== 10'(HS0) || vga_hs !== 1'b1) begin
      miscompares++;
      $display("FAIL hs_before_edge got x=%0d hs=%b expected x=%0d hs=1", x_cnt, vga_hs, HS0);
    end
    @(negedge clk);
    while (vga_hs === 1'b0 && low < HT) begin low++; @(negedge clk); end
    vectors++;
    if (low != HSW) begin
      miscompares++;
      $display("FAIL hs_width got %0d clks expected %0d", low, HSW);
    end
  endtask

  task automatic test_vsync();
    int n = 0, low = 0;
    do begin @(negedge clk); n++; end while (vga_vs !== 1'b0 && n < FRAME + 2);
    vectors++;
    if (vga_vs !== 1'b0 || y_cnt !== 10'(VS0) || x_cnt !== 10'd1) begin
      miscompares++;
      $display("FAIL vs_start got vs=%b x=%0d y=%0d expected vs=0 x=1 y=%0d", vga_vs, x_cnt, y_cnt, VS0);
    end
    while (vga_vs === 1'b0 && low < FRAME) begin low++; @(negedge clk); end
    vectors++;
    if (low != VSW * HT) begin
      miscompares++;
      $display("FAIL vs_width got %0d clks expected %0d", low, VSW * HT);
    end
  endtask

  task automatic test_colour();
    int n = 0;
    r_data = 8'hAB; g_data = 8'hCD; b_data = 8'hEF;
    do begin @(negedge clk); n++; end while (!(x_cnt == 10'd1 && y_cnt < 10'(VA)) && n < FRAME + 2);
    vectors++;
    if ({vga_r, vga_g, vga_b} !== 24'hABCDEF || vga_blank_n !== 1'b1) begin
      miscompares++;
      $display("FAIL colour_active got rgb=%h bn=%b expected ABCDEF 1", {vga_r, vga_g, vga_b}, vga_blank_n);
    end
    n = 0;
    do begin @(negedge clk); n++; end while (x_cnt !== 10'(HA + 1) && n < HT + 2);
    vectors++;
    if ({vga_r, vga_g, vga_b} !== 24'h0 || vga_blank_n !== 1'b0) begin
      miscompares++;
      $display("FAIL colour_blank got rgb=%h bn=%b expected 000000 0", {vga_r, vga_g, vga_b}, vga_blank_n);
    end
    // randomised colour, checked by the scoreboard
    for (int i = 0; i < 400; i++) begin
      r_data = 8'($urandom_range(0, 255));
      g_data = 8'($urandom_range(0, 255));
      b_data = 8'($urandom_range(0, 255));
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    r_data = 8'hAB; g_data = 8'hCD; b_data = 8'hEF;
    do begin @(negedge clk); n++; end while (!(x_cnt == 10'd30 && y_cnt == 10'd5) && n < FRAME + 2);
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({x_cnt, y_cnt, vga_hs, vga_vs, vga_blank_n, vga_r, vga_g, vga_b, frame_start} !==
        {10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 24'h0, 1'b0}) begin
      miscompares++;
      $display("FAIL async_reset got x=%0d y=%0d hs=%b vs=%b bn=%b rgb=%h fs=%b expected 0 0 1 1 0 000000 0",
               x_cnt, y_cnt, vga_hs, vga_vs, vga_blank_n, {vga_r, vga_g, vga_b}, frame_start);
    end
    repeat (3) @(negedge clk);
    vectors++;
    if ({x_cnt, y_cnt, frame_start} !== 21'd0) begin
      miscompares++;
      $display("FAIL reset_hold got x=%0d y=%0d fs=%b expected 0 0 0", x_cnt, y_cnt, frame_start);
    end
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if ({x_cnt, y_cnt} !== {10'd1, 10'd0}) begin
      miscompares++;
      $display("FAIL restart got x=%0d y=%0d expected 1 0", x_cnt, y_cnt);
    end
  endtask

`ifdef VGA_TEST_PATTERN_EN
  task automatic test_pattern();
    int px[3] = '{0, BW, 7 * BW};
    logic [23:0] want[3] = '{24'hFFFFFF, 24'hFFFF00, 24'h000000};
    int n;
    r_data = 8'h12; g_data = 8'h34; b_data = 8'h56;
    pattern_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      n = 0;
      do begin @(negedge clk); n++; end while (!(x_cnt == 10'(px[k] + 1) && y_cnt < 10'(VA)) && n < FRAME + 2);
      vectors++;
      if ({vga_r, vga_g, vga_b} !== want[k]) begin
        miscompares++;
        $display("FAIL pattern_x%0d got %h expected %h", px[k], {vga_r, vga_g, vga_b}, want[k]);
      end
    end
    pattern_en = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!(x_cnt == 10'd1 && y_cnt < 10'(VA)) && n < FRAME + 2);
    vectors++;
    if ({vga_r, vga_g, vga_b} !== 24'h123456) begin
      miscompares++;
      $display("FAIL pattern_off got %h expected 123456", {vga_r, vga_g, vga_b});
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    pattern_en = 1'b0;
    r_data = 8'h0; g_data = 8'h0; b_data = 8'h0;
    test_reset();
    test_frame_wrap();
    test_hsync();
    test_vsync();
    test_colour();
    test_reset_mid();
`ifdef VGA_TEST_PATTERN_EN
    test_pattern();
`endif
    repeat (4) @(negedge clk);
    #1;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL queue_drain got %0d pending expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
